// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - radix-2 shift-add 32x32 multiplier (MULT/MULTU) with start/done handshake.
// Optional early completion when no multiplier bits remain: define MUL_EARLY_DONE_EN.
module mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        sign,
  output logic [31:0] data_hi,
  output logic [31:0] data_lo,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic [63:0] p_q;
  logic [31:0] mcand_q;
  logic        neg_q;

  logic [32:0] sum_d;
  logic [63:0] p_step_d;
  logic [63:0] p_d;
  logic        last_d;
  logic [63:0] prod_d;

  // Operand magnitudes; -2^31 negates to itself, which is its correct unsigned magnitude.
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  assign mag_a = (sign & data_a[31]) ? (~data_a + 32'd1) : data_a;
  assign mag_b = (sign & data_b[31]) ? (~data_b + 32'd1) : data_b;

  always_comb begin
    sum_d    = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mcand_q} : 33'd0);
    p_step_d = {sum_d, p_q[31:1]};
  end

`ifdef MUL_EARLY_DONE_EN
  // Multiplier bits still waiting are p_q[31-count:1]; once they are all zero the
  // remaining iterations would only shift, so do that shift in one step.
  logic [31:0] pend_mask;
  logic [4:0]  align_sh;
  always_comb begin
    pend_mask = (32'hFFFF_FFFF >> count_q) & 32'hFFFF_FFFE;
    align_sh  = 5'd31 - count_q;
    last_d    = (count_q == 5'd31) || ((p_q[31:0] & pend_mask) == 32'd0);
    p_d       = last_d ? (p_step_d >> align_sh) : p_step_d;
  end
`else
  always_comb begin
    last_d = (count_q == 5'd31);
    p_d    = p_step_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= 5'd0;
      p_q     <= 64'd0;
      mcand_q <= 32'd0;
      neg_q   <= 1'b0;
    end else if (start) begin
      state_q <= S_BUSY;
      count_q <= 5'd0;
      p_q     <= {32'd0, mag_b};
      mcand_q <= mag_a;
      neg_q   <= sign & (data_a[31] ^ data_b[31]);
    end else if (state_q == S_BUSY) begin
      p_q     <= p_d;
      count_q <= count_q + 5'd1;
      if (last_d) begin
        state_q <= S_DONE;
      end
    end
  end

  assign busy    = (state_q == S_BUSY);
  assign done    = (state_q == S_DONE);
  assign prod_d  = neg_q ? (~p_q + 64'd1) : p_q;
  assign data_hi = prod_d[63:32];
  assign data_lo = prod_d[31:0];

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq (latency, product, abort, reset).
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_a = 32'd0;
  logic [31:0] data_b = 32'd0;
  logic        sign = 1'b0;
  logic [31:0] data_hi;
  logic [31:0] data_lo;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [63:0] prod;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];

  mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_a  (data_a),
    .data_b  (data_b),
    .sign    (sign),
    .data_hi (data_hi),
    .data_lo (data_lo),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [31:0] mag;
    int          msb;
    ea     = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb     = s ? {{32{b[31]}}, b} : {32'd0, b};
    e.prod = ea * eb;
    mag    = (s & b[31]) ? (32'd0 - b) : b;
    msb    = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
`ifdef MUL_EARLY_DONE_EN
    e.lat = 32'(msb + 1);
`else
    e.lat = 32'd32;
`endif
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    data_a = a;
    data_b = b;
    sign   = s;
    start  = 1'b1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
    sign   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      check_eq({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, " latency"}, 64'(n), 64'(e.lat));
      check_eq({tag, " product"}, {data_hi, data_lo}, e.prod);
      check_eq({tag, " busy_low"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    start_op(a, b, s);
    wait_done(tag);
  endtask

  initial begin
    int saw_done;
    logic [63:0] held;

    #12;
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset hi", 64'(data_hi), 64'd0);
    check_eq("reset lo", 64'(data_lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle stays idle", 64'({busy, done}), 64'd0);

    run_op("u_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("u_ffff exact", {data_hi, data_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1);
    check_eq("s_m3x7 exact", {data_hi, data_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("u_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b0);
    check_eq("u_m3x7 exact", {data_hi, data_lo}, 64'h0000_0006_FFFF_FFEB);
    run_op("s_min2", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check_eq("s_min2 exact", {data_hi, data_lo}, 64'h4000_0000_0000_0000);
    run_op("u_min_x2", 32'h8000_0000, 32'd2, 1'b0);
    run_op("s_pos_neg", 32'd12345, 32'hFFFF_FF00, 1'b1);
    run_op("s_zero", 32'd0, 32'hDEAD_BEEF, 1'b1);

    held = {data_hi, data_lo};
    repeat (4) @(negedge clk);
    check_eq("done held", 64'(done), 64'd1);
    check_eq("result held", {data_hi, data_lo}, held);

    // Start while done: done must drop at the sampling edge.
    start_op(32'd9, 32'h0001_0000, 1'b0);
    check_eq("restart drops done", 64'({busy, done}), 64'b10);
    wait_done("restart");

    // Abort: a second start replaces the first without any done for it.
    start_op(32'd5, 32'd6, 1'b0);
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check_eq("abort no done", 64'(saw_done), 64'd0);
    void'(sb.pop_front());
    run_op("after_abort", 32'd7, 32'd8, 1'b0);
    check_eq("after_abort lo", 64'(data_lo), 64'd56);

    // Asynchronous reset mid-operation.
    start_op(32'h1234_5678, 32'h8765_4321, 1'b0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    check_eq("rst product", {data_hi, data_lo}, 64'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check_eq("post rst idle", 64'(saw_done), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

`ifdef MUL_EARLY_DONE_EN
    run_op("early b1", 32'h1234_5678, 32'd1, 1'b0);
    check_eq("early b1 lo", 64'(data_lo), 64'h1234_5678);
    run_op("early b0", 32'h1234_5678, 32'd0, 1'b0);
    run_op("early bmsb", 32'h1234_5678, 32'h8000_0000, 1'b0);
    run_op("early s_neg1", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
    run_op("early mid", 32'hCAFE_F00D, 32'h0000_0155, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
